video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Parametrised raster timing generator for the HDMI transmit path, running in the pixel clock domain.
- Generalises the fixed-mode timing core:
  - any resolution and sync polarity, set by parameters;
  - run/stall enable;
  - a lookahead request port, so a renderer with LOOKAHEAD cycles of latency gets pixel coordinates early;
  - sync and position outputs delay-aligned to that renderer's output.
- Feeds the TMDS encoders (syncs, active) and the game renderer (request coordinates).

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HSYNC_POL, 1, 1 = hsync active-high, 0 = active-low
- VSYNC_POL, 1, same meaning for vsync
- LOOKAHEAD, 2, display outputs lag request outputs by this many enabled cycles (0..15)
- CW, 12, counter/position width; H_TOTAL and V_TOTAL must each be ≤ 2^CW

Ports:
- pixel_clk  in  1  pixel clock
- resetn  in  1  asynchronous active-low reset
- en  in  1  advance enable; when low, all state holds
- req_valid  out  1  request pixel lies in the active region
- req_hpos  out  CW  request horizontal counter
- req_vpos  out  CW  request vertical counter
- hsync  out  1  display-aligned hsync, polarity per HSYNC_POL
- vsync  out  1  display-aligned vsync, polarity per VSYNC_POL
- hblank  out  1  display-aligned horizontal blanking
- vblank  out  1  display-aligned vertical blanking
- active  out  1  display-aligned active video (~hblank & ~vblank)
- fsync  out  1  display-aligned one-cycle start-of-frame pulse
- hpos  out  CW  display-aligned horizontal counter
- vpos  out  CW  display-aligned vertical counter
- frame_cnt  out  16  frames started, wraps modulo 2^16

Behaviour:
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL is defined the same way.
- Region order within a line: active [0, H_ACTIVE), then FP, then SYNC, then BP. Vertical regions use the same order, in lines.
- Counters hcnt and vcnt:
  - reset to 0;
  - on each pixel_clk edge with en=1, hcnt increments;
  - at hcnt = H_TOTAL-1, hcnt wraps to 0 and vcnt increments;
  - at (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- Request stage, registered. On each enabled edge it captures the decode of the current (hcnt, vcnt):
  - req_hpos = hcnt, req_vpos = vcnt (raw counters, not zeroed in blanking);
  - req_valid = hcnt < H_ACTIVE && vcnt < V_ACTIVE.
- Display-stage decode, taken from the same captured (hcnt, vcnt):
  - hsync is asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC);
  - vsync is asserted for whole lines with vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); vsync edges coincide with hcnt = 0;
  - hblank = hcnt ≥ H_ACTIVE; vblank = vcnt ≥ V_ACTIVE;
  - fsync = (hcnt == 0 && vcnt == 0).
- Display delay: display outputs equal the request-stage-aligned decode delayed by exactly LOOKAHEAD enabled cycles, through a shift pipeline that advances only when en=1.
  - LOOKAHEAD = 0 means the display outputs are coincident with the request stage.
- frame_cnt increments on the edge where display-aligned fsync is registered high.
- Reset values:
  - counters, req_* and frame_cnt are 0;
  - hpos and vpos are 0;
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL;
  - active, fsync, hblank and vblank are 0;
  - the whole delay pipeline holds these same values.
- First enabled edge after reset: req_valid = 1 at request position (0,0). fsync pulses LOOKAHEAD enabled edges later; with LOOKAHEAD = 0, fsync is high after the first enabled edge.
- en low: no counter, pipeline or output changes. A pulse output (fsync) that is high stays high until the next enabled edge.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). Deassertion is synchronised upstream.

Decomposition:
- Package video_timing_pkg holds:
  - 720p60 default constants;
  - a small-mode test constant set;
  - packed struct vt_sig_t {hsync, vsync, hblank, vblank, active, fsync, hpos, vpos}.
- Sub-module sig_delay: parametrised WIDTH/DEPTH shift register with enable and async active-low reset. DEPTH = 0 is a pass-through. It carries vt_sig_t.

Test Plan:
All scenarios use the small mode (H 8/2/2/2, total 14; V 4/1/1/1, total 7; frame 98 cycles) with LOOKAHEAD = 2 unless stated otherwise.
- Reset hold, en=1 → all outputs at reset values; hsync = 0 and vsync = 0 with positive polarity.
- Release reset, en=1:
  - req_valid is high for 8 of every 14 cycles on req_vpos 0..3;
  - hsync is high when hpos = 10,11;
  - vsync is high for all 14 cycles of vpos = 5;
  - fsync asserts 2 cycles after req (0,0), with hpos = 0, vpos = 0.
- Run 3 frames → fsync period exactly 98 cycles; frame_cnt = 3; hpos/vpos wrap from (13,6) to (0,0).
- Drop en for 5 cycles at req_hpos = 6 → every output is frozen for those 5 cycles; the sequence resumes with no skipped or repeated position.
- Assert resetn low at vpos = 2 → outputs return to reset values asynchronously; after release the frame restarts from (0,0) and frame_cnt is 0.
- HSYNC_POL = 0, VSYNC_POL = 0, LOOKAHEAD = 0 → syncs idle high, pulse low at the same positions; display outputs coincide with the request stage.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared constants and the display-stage signal bundle for the raster timing generator.
// Position fields in vt_sig_t are VT_CW bits wide, so CW must not exceed VT_CW.
package video_timing_pkg;

    localparam int VT_CW = 12;

    // 1280x720p60
    localparam int HD_H_ACTIVE = 1280;
    localparam int HD_H_FP     = 110;
    localparam int HD_H_SYNC   = 40;
    localparam int HD_H_BP     = 220;
    localparam int HD_V_ACTIVE = 720;
    localparam int HD_V_FP     = 5;
    localparam int HD_V_SYNC   = 5;
    localparam int HD_V_BP     = 20;

    // Tiny raster: 14 x 7, 98 pixels per frame
    localparam int SM_H_ACTIVE = 8;
    localparam int SM_H_FP     = 2;
    localparam int SM_H_SYNC   = 2;
    localparam int SM_H_BP     = 2;
    localparam int SM_V_ACTIVE = 4;
    localparam int SM_V_FP     = 1;
    localparam int SM_V_SYNC   = 1;
    localparam int SM_V_BP     = 1;

    typedef struct packed {
        logic             hsync;
        logic             vsync;
        logic             hblank;
        logic             vblank;
        logic             active;
        logic             fsync;
        logic [VT_CW-1:0] hpos;
        logic [VT_CW-1:0] vpos;
    } vt_sig_t;

    localparam int VT_SIG_W     = $bits(vt_sig_t);
    localparam int VT_FSYNC_BIT = 2 * VT_CW;

    function automatic int vt_total(input int act, input int fp,
                                    input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_sig_delay.sv
// Enabled shift register with asynchronous reset to a fixed value.
// tap_next is the value one chosen bit of dout will take after the coming edge.
module sig_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter int               TAP     = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             tap_next
);

    if (DEPTH == 0) begin : g_pass
        assign dout     = din;
        assign tap_next = din[TAP];
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d = stage_q;
            if (en) begin
                stage_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign dout     = stage_q[DEPTH-1];
        assign tap_next = stage_d[DEPTH-1][TAP];
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: request-stage coordinates for a LOOKAHEAD-latency
// renderer, plus syncs/blanking delayed to line up with that renderer's pixels.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE  = HD_H_ACTIVE,
    parameter int H_FP      = HD_H_FP,
    parameter int H_SYNC    = HD_H_SYNC,
    parameter int H_BP      = HD_H_BP,
    parameter int V_ACTIVE  = HD_V_ACTIVE,
    parameter int V_FP      = HD_V_FP,
    parameter int V_SYNC    = HD_V_SYNC,
    parameter int V_BP      = HD_V_BP,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1,
    parameter int LOOKAHEAD = 2,
    parameter int CW        = 12
) (
    input  logic          pixel_clk,
    input  logic          resetn,
    input  logic          en,
    output logic          req_valid,
    output logic [CW-1:0] req_hpos,
    output logic [CW-1:0] req_vpos,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          active,
    output logic          fsync,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic [15:0]   frame_cnt
);

    localparam int H_TOTAL = vt_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vt_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SY_S = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SY_L = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] V_SY_S = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SY_L = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam vt_sig_t SIG_RST = '{
        hsync:  (HSYNC_POL == 0),
        vsync:  (VSYNC_POL == 0),
        hblank: 1'b0,
        vblank: 1'b0,
        active: 1'b0,
        fsync:  1'b0,
        hpos:   '0,
        vpos:   '0
    };

    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          req_valid_q, req_valid_d;
    logic [CW-1:0] req_hpos_q, req_hpos_d;
    logic [CW-1:0] req_vpos_q, req_vpos_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic    h_act, v_act, h_sy, v_sy;
    logic    fsync_nxt;
    vt_sig_t cur;
    vt_sig_t disp;

    assign h_act = hcnt_q < H_ACT;
    assign v_act = vcnt_q < V_ACT;
    assign h_sy  = (hcnt_q >= H_SY_S) && (hcnt_q <= H_SY_L);
    assign v_sy  = (vcnt_q >= V_SY_S) && (vcnt_q <= V_SY_L);

    always_comb begin
        cur        = SIG_RST;
        cur.hsync  = (HSYNC_POL != 0) ? h_sy : ~h_sy;
        cur.vsync  = (VSYNC_POL != 0) ? v_sy : ~v_sy;
        cur.hblank = ~h_act;
        cur.vblank = ~v_act;
        cur.active = h_act & v_act;
        cur.fsync  = (hcnt_q == '0) && (vcnt_q == '0);
        cur.hpos   = VT_CW'(hcnt_q);
        cur.vpos   = VT_CW'(vcnt_q);
    end

    always_comb begin
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        req_valid_d = req_valid_q;
        req_hpos_d  = req_hpos_q;
        req_vpos_d  = req_vpos_q;
        frame_cnt_d = frame_cnt_q;
        if (en) begin
            req_valid_d = h_act & v_act;
            req_hpos_d  = hcnt_q;
            req_vpos_d  = vcnt_q;
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
            end else begin
                hcnt_d = hcnt_q + CW'(1);
            end
            // count on the same edge the display-aligned fsync goes high
            if (fsync_nxt) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge resetn) begin
        if (!resetn) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            req_valid_q <= 1'b0;
            req_hpos_q  <= '0;
            req_vpos_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            req_valid_q <= req_valid_d;
            req_hpos_q  <= req_hpos_d;
            req_vpos_q  <= req_vpos_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // first stage registers alongside the request outputs
    sig_delay #(
        .WIDTH   (VT_SIG_W),
        .DEPTH   (LOOKAHEAD + 1),
        .TAP     (VT_FSYNC_BIT),
        .RST_VAL (SIG_RST)
    ) u_sig_delay (
        .clk      (pixel_clk),
        .rst_n    (resetn),
        .en       (en),
        .din      (cur),
        .dout     (disp),
        .tap_next (fsync_nxt)
    );

    assign req_valid = req_valid_q;
    assign req_hpos  = req_hpos_q;
    assign req_vpos  = req_vpos_q;
    assign hsync     = disp.hsync;
    assign vsync     = disp.vsync;
    assign hblank    = disp.hblank;
    assign vblank    = disp.vblank;
    assign active    = disp.active;
    assign fsync     = disp.fsync;
    assign hpos      = CW'(disp.hpos);
    assign vpos      = CW'(disp.vpos);
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen in the 14x7 mode: lookahead-2 positive
// syncs alongside lookahead-0 negative syncs, against a small position model.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int CW = 12;

    logic clk, rstn, en;

    logic          a_req_valid, a_hsync, a_vsync, a_hblank, a_vblank;
    logic          a_active, a_fsync;
    logic [CW-1:0] a_req_hpos, a_req_vpos, a_hpos, a_vpos;
    logic [15:0]   a_frame_cnt;

    logic          b_req_valid, b_hsync, b_vsync, b_hblank, b_vblank;
    logic          b_active, b_fsync;
    logic [CW-1:0] b_req_hpos, b_req_vpos, b_hpos, b_vpos;
    logic [15:0]   b_frame_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(SM_H_ACTIVE), .H_FP(SM_H_FP), .H_SYNC(SM_H_SYNC), .H_BP(SM_H_BP),
        .V_ACTIVE(SM_V_ACTIVE), .V_FP(SM_V_FP), .V_SYNC(SM_V_SYNC), .V_BP(SM_V_BP),
        .HSYNC_POL(1), .VSYNC_POL(1), .LOOKAHEAD(2), .CW(CW)
    ) u_a (
        .pixel_clk(clk), .resetn(rstn), .en(en),
        .req_valid(a_req_valid), .req_hpos(a_req_hpos), .req_vpos(a_req_vpos),
        .hsync(a_hsync), .vsync(a_vsync), .hblank(a_hblank), .vblank(a_vblank),
        .active(a_active), .fsync(a_fsync), .hpos(a_hpos), .vpos(a_vpos),
        .frame_cnt(a_frame_cnt)
    );

    video_timing_gen #(
        .H_ACTIVE(SM_H_ACTIVE), .H_FP(SM_H_FP), .H_SYNC(SM_H_SYNC), .H_BP(SM_H_BP),
        .V_ACTIVE(SM_V_ACTIVE), .V_FP(SM_V_FP), .V_SYNC(SM_V_SYNC), .V_BP(SM_V_BP),
        .HSYNC_POL(0), .VSYNC_POL(0), .LOOKAHEAD(0), .CW(CW)
    ) u_b (
        .pixel_clk(clk), .resetn(rstn), .en(en),
        .req_valid(b_req_valid), .req_hpos(b_req_hpos), .req_vpos(b_req_vpos),
        .hsync(b_hsync), .vsync(b_vsync), .hblank(b_hblank), .vblank(b_vblank),
        .active(b_active), .fsync(b_fsync), .hpos(b_hpos), .vpos(b_vpos),
        .frame_cnt(b_frame_cnt)
    );

    int checks;
    int errors;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit rst;
        int h;
        int v;
    } mpos_t;

    // hist[0] is the request stage, hist[2] the lookahead-2 display stage
    mpos_t hist [3];
    int    mh, mv, fc_a, fc_b;

    function automatic void model_rst();
        mh = 0;
        mv = 0;
        fc_a = 0;
        fc_b = 0;
        for (int i = 0; i < 3; i++) hist[i] = '{rst: 1'b1, h: 0, v: 0};
    endfunction

    function automatic void model_adv();
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = '{rst: 1'b0, h: mh, v: mv};
        if (mh == 13) begin
            mh = 0;
            mv = (mv == 6) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        if (!hist[2].rst && hist[2].h == 0 && hist[2].v == 0) fc_a++;
        if (!hist[0].rst && hist[0].h == 0 && hist[0].v == 0) fc_b++;
    endfunction

    // {hsync, vsync, hblank, vblank, active, fsync} for the 14x7 raster
    function automatic logic [5:0] exp_sig(input mpos_t p, input bit pol);
        bit hs, vs, hb, vb, fs;
        if (p.rst) return {~pol, ~pol, 4'b0000};
        hs = (p.h == 10) || (p.h == 11);
        vs = (p.v == 5);
        hb = (p.h >= 8);
        vb = (p.v >= 4);
        fs = (p.h == 0) && (p.v == 0);
        return {pol ? hs : !hs, pol ? vs : !vs, hb, vb, !hb && !vb, fs};
    endfunction

    task automatic check_all();
        mpos_t r, d;
        r = hist[0];
        d = hist[2];
        check("a_req_valid", 32'(a_req_valid), 32'(!r.rst && r.h < 8 && r.v < 4));
        check("a_req_hpos", 32'(a_req_hpos), r.rst ? 0 : r.h);
        check("a_req_vpos", 32'(a_req_vpos), r.rst ? 0 : r.v);
        check("a_sig", 32'({a_hsync, a_vsync, a_hblank, a_vblank, a_active, a_fsync}),
              32'(exp_sig(d, 1'b1)));
        check("a_hpos", 32'(a_hpos), d.rst ? 0 : d.h);
        check("a_vpos", 32'(a_vpos), d.rst ? 0 : d.v);
        check("a_frame_cnt", 32'(a_frame_cnt), fc_a);
        check("b_req_valid", 32'(b_req_valid), 32'(!r.rst && r.h < 8 && r.v < 4));
        check("b_req_pos", 32'({b_req_hpos, b_req_vpos}),
              r.rst ? 0 : (r.h << CW) | r.v);
        check("b_sig", 32'({b_hsync, b_vsync, b_hblank, b_vblank, b_active, b_fsync}),
              32'(exp_sig(r, 1'b0)));
        check("b_pos", 32'({b_hpos, b_vpos}), r.rst ? 0 : (r.h << CW) | r.v);
        check("b_frame_cnt", 32'(b_frame_cnt), fc_b);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rstn && en) model_adv();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int first_fs, prev_fs, nfs, nvalid, nvs, nhs;
        logic [CW-1:0] ph, pv;
        logic [23:0] s_req, s_pos;
        logic [21:0] s_sig;

        checks = 0;
        errors = 0;
        rstn = 1'b1;
        en = 1'b1;
        model_rst();
        #1 rstn = 1'b0;

        repeat (3) cyc();
        check("rst_hsync_pos", 32'(a_hsync), 0);
        check("rst_vsync_pos", 32'(a_vsync), 0);
        check("rst_syncs_neg", 32'({b_hsync, b_vsync}), 3);

        rstn = 1'b1;
        first_fs = -1;
        prev_fs = -1;
        nfs = 0;
        nvalid = 0;
        nvs = 0;
        nhs = 0;
        ph = '0;
        pv = '0;
        for (int n = 1; n <= 296; n++) begin
            cyc();
            if (n == 1) begin
                check("first_req_valid", 32'(a_req_valid), 1);
                check("first_req_pos", 32'({a_req_hpos, a_req_vpos}), 0);
                check("b_first_fsync", 32'(b_fsync), 1);
            end
            if (n <= 98) begin
                nvalid += int'(a_req_valid);
                nvs += int'(a_vsync);
                nhs += int'(a_hsync);
            end
            if (a_hsync) check("hsync_at", 32'((a_hpos == 10) || (a_hpos == 11)), 1);
            if (a_fsync) begin
                if (first_fs < 0) first_fs = n;
                else check("fsync_period", n - prev_fs, 98);
                prev_fs = n;
                nfs++;
                check("fsync_pos", 32'({a_hpos, a_vpos}), 0);
            end
            if (ph == 13 && pv == 6) check("pos_wrap", 32'({a_hpos, a_vpos}), 0);
            ph = a_hpos;
            pv = a_vpos;
        end
        check("fsync_latency", first_fs, 3);
        check("fsync_count", nfs, 3);
        check("frame_cnt_3", 32'(a_frame_cnt), 3);
        check("req_valid_frame", nvalid, 32);
        check("vsync_cycles", nvs, 14);
        check("hsync_cycles", nhs, 14);

        for (int k = 0; k < 200 && a_req_hpos != 12'd6; k++) cyc();
        check("reach_req_hpos6", 32'(a_req_hpos), 6);
        s_req = {a_req_hpos, a_req_vpos};
        s_sig = {a_hsync, a_vsync, a_hblank, a_vblank, a_active, a_fsync, a_frame_cnt};
        s_pos = {a_hpos, a_vpos};
        en = 1'b0;
        repeat (5) begin
            cyc();
            check("freeze_req", 32'({a_req_hpos, a_req_vpos}), 32'(s_req));
            check("freeze_sig", 32'({a_hsync, a_vsync, a_hblank, a_vblank,
                                     a_active, a_fsync, a_frame_cnt}), 32'(s_sig));
            check("freeze_pos", 32'({a_hpos, a_vpos}), 32'(s_pos));
        end
        en = 1'b1;
        cyc();
        check("resume_req_hpos", 32'(a_req_hpos), 7);

        for (int k = 0; k < 200 && a_vpos != 12'd2; k++) cyc();
        check("reach_vpos2", 32'(a_vpos), 2);
        rstn = 1'b0;
        #1;
        model_rst();
        check_all();
        check("async_rst_fc", 32'(a_frame_cnt), 0);
        repeat (2) cyc();
        rstn = 1'b1;
        cyc();
        check("restart_req_pos", 32'({a_req_hpos, a_req_vpos}), 0);
        check("restart_fc0", 32'(a_frame_cnt), 0);
        repeat (2) cyc();
        check("restart_fsync", 32'(a_fsync), 1);
        check("restart_fc1", 32'(a_frame_cnt), 1);
        repeat (100) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
